// File: rtl/game_pkg.sv
// Shared state encoding and constants for the note-memory round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_START,
    S_PLAY,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int unsigned TICK_MAX_DEFAULT = 5000000;
  localparam int SONG_W = 32;
  localparam int NOTE_W = 4;
  localparam logic [3:0] ROUNDS_SAT = 4'd15;

endpackage

// File: rtl/game_round_ctrl_key_debounce.sv
// Keypad debouncer: one strobe per held key, re-armed only by an idle (zero) sample.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NOTE_W-1:0] key_raw,
  output logic              keypad_enable,
  output logic [NOTE_W-1:0] keypad_code
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic [NOTE_W-1:0] prev_q;
  logic [NOTE_W-1:0] code_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic              lock_q;
  logic              same;
  logic              accept;

  // Counter saturates so a long hold cannot wrap into a second accept.
  always_comb begin
    same    = (key_raw != '0) && (key_raw == prev_q);
    cnt_nxt = '0;
    if (same) begin
      cnt_nxt = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
    end
    accept = enable && !lock_q && (key_raw != '0) && (cnt_nxt == CMAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      code_q <= '0;
    end else if (!enable) begin
      prev_q <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      prev_q <= key_raw;
      cnt_q  <= cnt_nxt;
      if (accept) begin
        lock_q <= 1'b1;
        code_q <= key_raw;
      end else if (key_raw == '0) begin
        lock_q <= 1'b0;
      end
    end
  end

  assign keypad_enable = accept;
  assign keypad_code   = accept ? key_raw : code_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the note-memory game datapath.
// Define GAME_SHUFFLE_EN to rotate the song order by an LFSR-chosen offset.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT,
  parameter int NUM_SONGS = 4,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_btn,
  input  logic [NOTE_W-1:0]           key_raw,
  input  logic [SONG_W*NUM_SONGS-1:0] song_bank,
  input  logic                        game_end,
  output logic                        game_rst,
  output logic [SONG_W-1:0]           data_out,
  output logic                        write_enable,
  output logic                        game_start,
  output logic                        keypad_enable,
  output logic [NOTE_W-1:0]           keypad_code,
  output logic [2:0]                  round_num,
  output logic [3:0]                  rounds_cleared,
  output logic                        busy,
  output logic                        session_done,
  output logic                        timeout_flag
);

  localparam int LW = $clog2(NUM_SONGS);
  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [LW-1:0] LAST = LW'(NUM_SONGS - 1);

  state_t state_q;
  state_t state_nxt;

  logic [TW-1:0] tcnt_q;
  logic          tick;
  logic          start_q;
  logic          rise;
  logic          session_start;
  logic          play_en;
  logic          last_round;
  logic [LW-1:0] slot;
  logic [LW-1:0] offset_q;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_nxt;
  logic          timeout;

  assign tick = (tcnt_q == TW'(TICK_MAX - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
    end
  end

  // Edge register tracks the button in every state so no stale edge survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_btn;
    end
  end

  assign rise = start_btn && !start_q;
  assign session_start = rise &&
    ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef GAME_SHUFFLE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q   <= 8'h01;
      offset_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (session_start) begin
        offset_q <= lfsr_q[LW-1:0];
      end
    end
  end
`else
  assign offset_q = '0;
`endif

  assign slot       = round_num[LW-1:0] + offset_q;
  assign last_round = (round_num[LW-1:0] == LAST);

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk          (clk),
    .reset        (reset),
    .enable       (play_en),
    .key_raw      (key_raw),
    .keypad_enable(keypad_enable),
    .keypad_code  (keypad_code)
  );

  // A press in the same cycle as a tick wins: the player was active.
  always_comb begin
    idle_nxt = idle_q;
    if (keypad_enable) begin
      idle_nxt = '0;
    end else if (tick) begin
      idle_nxt = idle_q + 1'b1;
    end
    timeout = (idle_nxt == IW'(TIMEOUT_TICKS));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_nxt = S_RST;
      S_DONE:  if (rise) state_nxt = S_RST;
      S_RST:   state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: state_nxt = S_PLAY;
      S_PLAY: begin
        if (game_end) begin
          state_nxt = S_NEXT;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_NEXT:  state_nxt = last_round ? S_DONE : S_RST;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    game_rst     = !reset;
    write_enable = 1'b0;
    game_start   = 1'b0;
    busy         = 1'b1;
    session_done = 1'b0;
    play_en      = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_RST:   game_rst = 1'b1;
      S_LOAD:  write_enable = 1'b1;
      S_START: game_start = 1'b1;
      S_PLAY:  play_en = 1'b1;
      S_DONE: begin
        busy         = 1'b0;
        session_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      round_num      <= '0;
      rounds_cleared <= '0;
      timeout_flag   <= 1'b0;
      data_out       <= '0;
      idle_q         <= '0;
    end else begin
      if (session_start) begin
        round_num      <= '0;
        rounds_cleared <= '0;
        timeout_flag   <= 1'b0;
      end
      if (state_q == S_RST) begin
        data_out <= song_bank[int'(slot)*SONG_W +: SONG_W];
      end
      if (state_q == S_START) begin
        idle_q <= '0;
      end
      if (state_q == S_PLAY) begin
        idle_q <= idle_nxt;
        if (game_end) begin
          if (rounds_cleared != ROUNDS_SAT) begin
            rounds_cleared <= rounds_cleared + 1'b1;
          end
        end else if (timeout) begin
          timeout_flag <= 1'b1;
        end
      end
      if ((state_q == S_NEXT) && !last_round) begin
        round_num <= round_num + 1'b1;
      end
    end
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequencer for the note-memory game datapath: resets it, loads a 32-bit song pattern, and starts each round.
- Forwards debounced keypad presses as single-cycle keypad_enable pulses and counts cleared rounds.
- Aborts on player inactivity.
- Sits between board inputs (buttons, keypad matrix decode) and one game datapath instance.

Parameters:
- TICK_MAX, 5000000, clock cycles per timebase tick (same tick as the game datapath).
- NUM_SONGS, 4, songs per session; power of two, 2..8.
- DEB_CYCLES, 4, consecutive identical nonzero key samples required before a press is accepted.
- TIMEOUT_TICKS, 40, ticks with no accepted press in PLAY before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is synchronous and active-low.
- start_btn  in  1  level; session start/restart, acted on at its rising edge.
- key_raw  in  4  raw key code; 0 = no key.
- song_bank  in  32*NUM_SONGS  flat song patterns; song i is bits [32*i+31:32*i].
- game_end  in  1  level from datapath; round finished.
- game_rst  out  1  active-high reset pulse to datapath.
- data_out  out  32  song pattern to datapath data_in.
- write_enable  out  1  one-cycle load strobe.
- game_start  out  1  one-cycle start strobe.
- keypad_enable  out  1  one-cycle accepted-press strobe.
- keypad_code  out  4  accepted code; held until the next accept.
- round_num  out  3  current song slot.
- rounds_cleared  out  4  completed rounds, saturating at 15.
- busy  out  1  high in every state except IDLE and DONE.
- session_done  out  1  high in DONE.
- timeout_flag  out  1  sticky; cleared on new session.

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE.
  - All outputs 0, except game_rst=1 while reset is held.
  - Tick counter, idle counter, debounce counter and start edge register cleared.
- Timebase: tick counter 0..TICK_MAX-1 wraps; tick pulse at count TICK_MAX-1.
- FSM states: IDLE, RST, LOAD, START, PLAY, NEXT, DONE.
- IDLE: start_btn rising edge -> RST; round_num=0, rounds_cleared=0, timeout_flag=0.
- RST: game_rst=1 for exactly 1 cycle -> LOAD.
- LOAD: data_out=song[slot]; write_enable=1 for 1 cycle -> START.
  - data_out stays stable from LOAD until the next LOAD.
- START: game_start=1 for 1 cycle -> PLAY. Idle counter cleared.
- PLAY:
  - Debouncer active. A nonzero key_raw equal to the previous sample increments the debounce counter; any change resets it.
  - Counter reaching DEB_CYCLES-1 -> keypad_enable=1 one cycle, keypad_code=key_raw, debouncer locked.
  - Debouncer unlocks only after key_raw==0 is sampled. A held key produces exactly one pulse.
  - Each accepted press clears the idle counter; each tick increments it.
  - game_end==1 -> NEXT; rounds_cleared += 1 (saturating).
  - Idle counter reaching TIMEOUT_TICKS -> timeout_flag=1, DONE.
  - game_end and timeout in the same cycle: game_end wins, and the idle counter is discarded.
  - A press accepted in the same cycle as game_end is still pulsed.
- NEXT:
  - round_num==NUM_SONGS-1 -> DONE.
  - Otherwise round_num += 1 -> RST (fresh datapath reset, then load).
- DONE: session_done=1, busy=0. start_btn rising edge -> IDLE-entry actions, then RST (new session).
- start_btn in RST..NEXT is ignored; the edge register still updates, so no stale edge is acted on.
- Outside PLAY: debouncer held cleared; keypad_enable forced 0.
- key_raw changes during LOAD/START are not forwarded.
- Slot: slot = (round_num + offset) mod NUM_SONGS, where offset=0 unless the optional feature is enabled.
- Widths: round_num compares use log2(NUM_SONGS) bits, zero-extended to 3.

Optional Feature:
- GAME_SHUFFLE_EN defined:
  - A free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 at reset) advances every cycle.
  - At each session start, offset = LFSR[log2(NUM_SONGS)-1:0].
- Undefined: offset is constant 0 and no LFSR is instantiated.

Decomposition:
- Shared package game_pkg holds:
  - the state enum;
  - TICK_MAX_DEFAULT = 5000000;
  - SONG_W = 32;
  - NOTE_W = 4;
  - the rounds_cleared saturation constant.
- One sub-module is natural: key_debounce (key_raw, enable, DEB_CYCLES -> keypad_enable, keypad_code).

Test Plan:
Bench overrides: TICK_MAX=10, DEB_CYCLES=4, TIMEOUT_TICKS=3, NUM_SONGS=4.
- Reset then start_btn pulse -> game_rst 1 cycle, then write_enable with data_out=song[0], then game_start on the next cycle; busy=1.
- In PLAY, key_raw=4'h3 held for 20 cycles -> exactly one keypad_enable, keypad_code=3. key_raw=0 then 4'h5 for 4 cycles -> a second pulse with code 5. A 3-cycle glitch of 4'h2 -> no pulse.
- game_end asserted in each of 4 rounds -> round_num 0,1,2,3, then session_done=1, rounds_cleared=4, data_out=song[3] at the last load.
- No key for 30 cycles in PLAY -> timeout_flag=1 and session_done=1 at the 3rd tick. game_end in that same cycle instead -> NEXT, timeout_flag=0.
- reset driven low mid-PLAY for 1 cycle -> state IDLE, all outputs 0, game_rst=1 during reset; a start_btn edge during busy is ignored.
- GAME_SHUFFLE_EN with forced LFSR low bits=2 -> first load uses song[2], then song[3], song[0], song[1].
